led_scan_driver: RTL and testbench

LED_SCAN_DRIVER -- requirements
Module: led_scan_driver

---
 rtl/led_pkg.sv | 25 ++
 rtl/led_pixel_gen.sv | 47 ++++
 rtl/led_scan_driver.sv | 184 ++++++++++++++++++
 tb/tb_led_scan_driver.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared FSM state type, default geometry and score column offsets for the LED scan driver.
package led_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_LATCH   = 2'd2,
      ST_DISPLAY = 2'd3
   } led_state_t;

   localparam int DEF_COLS        = 64;
   localparam int DEF_ROWS        = 64;
   localparam int DEF_PADDLE_LEN  = 8;
   localparam int DEF_SCORE_W     = 3;
   localparam int DEF_HOLD_CYCLES = 16;

   // Player 1 score grows rightwards from col 2; player 2 grows leftwards from COLS-3.
   localparam int SCORE1_COL            = 2;
   localparam int SCORE2_COL_FROM_RIGHT = 3;

   function automatic int score2_col(input int cols);
      return cols - SCORE2_COL_FROM_RIGHT;
   endfunction

endpackage

// File: rtl/led_pixel_gen.sv
// Combinational pixel(col,row) from the frame snapshot: ball, two paddles and optional score bars.
// Score bars on row 0 are drawn only when LED_SCORE_DISPLAY_EN is defined.
module led_pixel_gen
   import led_pkg::*;
#(
   parameter int COLS       = DEF_COLS,
   parameter int ROWS       = DEF_ROWS,
   parameter int PADDLE_LEN = DEF_PADDLE_LEN,
   parameter int SCORE_W    = DEF_SCORE_W
) (
   input  logic [$clog2(COLS)-1:0] col,
   input  logic [$clog2(ROWS)-1:0] row,
   input  logic [$clog2(COLS)-1:0] bx,
   input  logic [$clog2(ROWS)-1:0] by,
   input  logic [$clog2(ROWS)-1:0] p1y,
   input  logic [$clog2(ROWS)-1:0] p2y,
   input  logic [SCORE_W-1:0]      sc1,
   input  logic [SCORE_W-1:0]      sc2,
   output logic                    pixel
);

   logic ball_px;
   logic left_px;
   logic right_px;
   logic score_px;

   // Integer compares keep p+PADDLE_LEN from wrapping, which gives the bottom-edge clipping.
   always_comb begin
      ball_px  = (int'(col) == int'(bx)) && (int'(row) == int'(by)) && (int'(bx) < COLS) && (int'(by) < ROWS);
      left_px  = (int'(col) == 0) && (int'(row) >= int'(p1y)) && (int'(row) < int'(p1y) + PADDLE_LEN);
      right_px = (int'(col) == COLS - 1) && (int'(row) >= int'(p2y)) && (int'(row) < int'(p2y) + PADDLE_LEN);
`ifdef LED_SCORE_DISPLAY_EN
      score_px = (int'(row) == 0) &&
                 (((int'(col) >= SCORE1_COL) && (int'(col) < SCORE1_COL + int'(sc1))) ||
                  ((int'(col) <= score2_col(COLS)) && (int'(col) > score2_col(COLS) - int'(sc2))));
`else
      score_px = 1'b0;
`endif
      pixel = ball_px | left_px | right_px | score_px;
   end

`ifndef LED_SCORE_DISPLAY_EN
   logic unused_sc;
   assign unused_sc = ^{sc1, sc2};
`endif

endmodule

// File: rtl/led_scan_driver.sv
// Row-scanned LED matrix driver for a pong display: shifts each row serially, latches it, then holds it lit.
// Optional score bars on row 0 are enabled by defining LED_SCORE_DISPLAY_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | panel dark, waiting for enable; snapshot taken on exit
// ST_SHIFT   | two cycles per column (sclk low, then high), column 0 first
// ST_LATCH   | one-cycle latch strobe, row_addr moves to the shifted row
// ST_DISPLAY | oe_n low for HOLD_CYCLES, then next row or end of frame
module led_scan_driver
   import led_pkg::*;
#(
   parameter int COLS        = DEF_COLS,
   parameter int ROWS        = DEF_ROWS,
   parameter int PADDLE_LEN  = DEF_PADDLE_LEN,
   parameter int SCORE_W     = DEF_SCORE_W,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [$clog2(COLS)-1:0] bx,
   input  logic [$clog2(ROWS)-1:0] by,
   input  logic [$clog2(ROWS)-1:0] p1y,
   input  logic [$clog2(ROWS)-1:0] p2y,
   input  logic [SCORE_W-1:0]      sc1,
   input  logic [SCORE_W-1:0]      sc2,
   output logic                    sdata,
   output logic                    sclk,
   output logic                    latch,
   output logic                    oe_n,
   output logic [$clog2(ROWS)-1:0] row_addr,
   output logic                    frame_done
);

   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);
   localparam int HW = $clog2(HOLD_CYCLES + 1);

   led_state_t     state;
   logic [RW-1:0]  row_cnt;
   logic [CW-1:0]  col_cnt;
   logic           phase_b;
   logic [HW-1:0]  hold_cnt;

   logic [CW-1:0]      snap_bx;
   logic [RW-1:0]      snap_by;
   logic [RW-1:0]      snap_p1y;
   logic [RW-1:0]      snap_p2y;
   logic [SCORE_W-1:0] snap_sc1;
   logic [SCORE_W-1:0] snap_sc2;

   logic          last_row;
   logic          hold_done;
   logic          capture;
   logic [CW-1:0] pg_col;
   logic [RW-1:0] pg_row;
   logic          pix;

   // The first pixel of a new frame is registered on the same edge as the snapshot,
   // so the generator looks at the live inputs whenever a capture is possible.
   always_comb begin
      last_row  = (int'(row_cnt) == ROWS - 1);
      hold_done = (hold_cnt == '0);
      capture   = (state == ST_IDLE) || ((state == ST_DISPLAY) && hold_done && last_row);
      pg_col    = (state == ST_SHIFT) ? col_cnt + 1'b1 : '0;
      if (capture)
         pg_row = '0;
      else if (state == ST_DISPLAY)
         pg_row = row_cnt + 1'b1;
      else
         pg_row = row_cnt;
   end

   led_pixel_gen #(
      .COLS       (COLS),
      .ROWS       (ROWS),
      .PADDLE_LEN (PADDLE_LEN),
      .SCORE_W    (SCORE_W)
   ) u_pixel_gen (
      .col   (pg_col),
      .row   (pg_row),
      .bx    (capture ? bx  : snap_bx),
      .by    (capture ? by  : snap_by),
      .p1y   (capture ? p1y : snap_p1y),
      .p2y   (capture ? p2y : snap_p2y),
      .sc1   (capture ? sc1 : snap_sc1),
      .sc2   (capture ? sc2 : snap_sc2),
      .pixel (pix)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         row_cnt    <= '0;
         col_cnt    <= '0;
         phase_b    <= 1'b0;
         hold_cnt   <= '0;
         snap_bx    <= '0;
         snap_by    <= '0;
         snap_p1y   <= '0;
         snap_p2y   <= '0;
         snap_sc1   <= '0;
         snap_sc2   <= '0;
         sdata      <= 1'b0;
         sclk       <= 1'b0;
         latch      <= 1'b0;
         oe_n       <= 1'b1;
         row_addr   <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (capture && enable) begin
            snap_bx  <= bx;
            snap_by  <= by;
            snap_p1y <= p1y;
            snap_p2y <= p2y;
            snap_sc1 <= sc1;
            snap_sc2 <= sc2;
         end
         case (state)
            ST_IDLE: begin
               if (enable) begin
                  state   <= ST_SHIFT;
                  row_cnt <= '0;
                  col_cnt <= '0;
                  phase_b <= 1'b0;
                  sclk    <= 1'b0;
                  sdata   <= pix;
               end
            end
            ST_SHIFT: begin
               if (!phase_b) begin
                  phase_b <= 1'b1;
                  sclk    <= 1'b1;
               end else if (int'(col_cnt) == COLS - 1) begin
                  state    <= ST_LATCH;
                  phase_b  <= 1'b0;
                  sclk     <= 1'b0;
                  sdata    <= 1'b0;
                  latch    <= 1'b1;
                  row_addr <= row_cnt;
               end else begin
                  phase_b <= 1'b0;
                  col_cnt <= col_cnt + 1'b1;
                  sclk    <= 1'b0;
                  sdata   <= pix;
               end
            end
            ST_LATCH: begin
               state    <= ST_DISPLAY;
               latch    <= 1'b0;
               oe_n     <= 1'b0;
               hold_cnt <= HW'(HOLD_CYCLES - 1);
            end
            ST_DISPLAY: begin
               if (!hold_done) begin
                  hold_cnt <= hold_cnt - 1'b1;
               end else begin
                  oe_n    <= 1'b1;
                  col_cnt <= '0;
                  phase_b <= 1'b0;
                  if (last_row) begin
                     frame_done <= 1'b1;
                     row_cnt    <= '0;
                     if (enable) begin
                        state <= ST_SHIFT;
                        sdata <= pix;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end else begin
                     state   <= ST_SHIFT;
                     row_cnt <= row_cnt + 1'b1;
                     sdata   <= pix;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_led_scan_driver.sv
// Self-checking bench for led_scan_driver: random scenes checked against a pixel-rule model of each row.
// Score expectations follow LED_SCORE_DISPLAY_EN the same way the design build does.
module tb_led_scan_driver;

   localparam int COLS         = 64;
   localparam int ROWS         = 64;
   localparam int PADDLE_LEN   = 8;
   localparam int SCORE_W      = 3;
   localparam int HOLD_CYCLES  = 16;
   localparam int CW           = $clog2(COLS);
   localparam int RW           = $clog2(ROWS);
   localparam int ROW_PERIOD   = 2 * COLS + 1 + HOLD_CYCLES;
   localparam int FRAME_PERIOD = ROWS * ROW_PERIOD;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               enable = 1'b0;
   logic [CW-1:0]      bx = '0;
   logic [RW-1:0]      by = '0;
   logic [RW-1:0]      p1y = '0;
   logic [RW-1:0]      p2y = '0;
   logic [SCORE_W-1:0] sc1 = '0;
   logic [SCORE_W-1:0] sc2 = '0;
   logic               sdata;
   logic               sclk;
   logic               latch;
   logic               oe_n;
   logic [RW-1:0]      row_addr;
   logic               frame_done;

   always #5 clk = ~clk;

   led_scan_driver #(
      .COLS        (COLS),
      .ROWS        (ROWS),
      .PADDLE_LEN  (PADDLE_LEN),
      .SCORE_W     (SCORE_W),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .bx         (bx),
      .by         (by),
      .p1y        (p1y),
      .p2y        (p2y),
      .sc1        (sc1),
      .sc2        (sc2),
      .sdata      (sdata),
      .sclk       (sclk),
      .latch      (latch),
      .oe_n       (oe_n),
      .row_addr   (row_addr),
      .frame_done (frame_done)
   );

   typedef struct {
      int bx;
      int by;
      int p1y;
      int p2y;
      int sc1;
      int sc2;
   } scene_t;

   scene_t exp_scene;
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic scene_t live_scene();
      scene_t s;
      s.bx  = int'(bx);
      s.by  = int'(by);
      s.p1y = int'(p1y);
      s.p2y = int'(p2y);
      s.sc1 = int'(sc1);
      s.sc2 = int'(sc2);
      return s;
   endfunction

   // Expected row image straight from the drawing rules.
   function automatic logic [COLS-1:0] model_row(input int r, input scene_t s);
      logic [COLS-1:0] v;
      bit lit;
      v = '0;
      for (int c = 0; c < COLS; c++) begin
         lit = (c == s.bx) && (r == s.by);
         if (c == 0 && r >= s.p1y && r < s.p1y + PADDLE_LEN) lit = 1'b1;
         if (c == COLS - 1 && r >= s.p2y && r < s.p2y + PADDLE_LEN) lit = 1'b1;
`ifdef LED_SCORE_DISPLAY_EN
         if (r == 0 && c >= 2 && c < 2 + s.sc1) lit = 1'b1;
         if (r == 0 && c <= COLS - 3 && c > COLS - 3 - s.sc2) lit = 1'b1;
`endif
         v[c] = lit;
      end
      return v;
   endfunction

   int              cyc = 0;
   int              ncol = 0;
   int              exp_row = 0;
   int              oe_cnt = 0;
   int              last_latch = -1;
   int              last_fd = -1;
   int              rows_in_frame = 0;
   int              frame_idx = 0;
   int              latch_total = 0;
   int              fd_total = 0;
   int              last_latched_row = -1;
   logic            prev_sclk = 1'b0;
   logic [COLS-1:0] shifted = '0;
   logic [COLS-1:0] row0_exp;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         ncol = 0;
         exp_row = 0;
         oe_cnt = 0;
         last_latch = -1;
         last_fd = -1;
         rows_in_frame = 0;
         prev_sclk = 1'b0;
         shifted = '0;
      end else begin
         if (sclk && !prev_sclk) begin
            if (ncol < COLS) shifted[ncol] = sdata;
            ncol++;
         end
         prev_sclk = sclk;
         if (!oe_n) oe_cnt++;
         else if (oe_cnt != 0) begin
            chk("oe_low_cycles", oe_cnt, HOLD_CYCLES);
            oe_cnt = 0;
         end
         if (latch) begin
            latch_total++;
            chk("row_addr", row_addr, exp_row);
            chk("shift_count", ncol, COLS);
            chk($sformatf("pixels_row%0d", exp_row), shifted, model_row(exp_row, exp_scene));
            if (last_latch >= 0) chk("latch_spacing", cyc - last_latch, ROW_PERIOD);
            if (frame_idx == 0) begin
`ifdef LED_SCORE_DISPLAY_EN
               row0_exp = 64'h3800_0000_0000_007C;
`else
               row0_exp = '0;
`endif
               if (exp_row == 0)  chk("first_row0", shifted, row0_exp);
               if (exp_row == 20) chk("first_row20", shifted, 64'h8000_0000_0010_0001);
               if (exp_row == 27) chk("first_row27", shifted, 64'h8000_0000_0000_0001);
               if (exp_row == 28) chk("first_row28", shifted, 64'h0);
            end
            if (frame_idx == 1 && exp_row == 20) chk("next_frame_ball", {shifted[30], shifted[20]}, 2'b10);
            if (frame_idx == 2 && (exp_row == 0 || exp_row == 59 || exp_row == 60 || exp_row == 63))
               chk($sformatf("clip_left_row%0d", exp_row), shifted[0], exp_row >= 60);
            last_latched_row = exp_row;
            last_latch = cyc;
            exp_row = (exp_row + 1) % ROWS;
            rows_in_frame++;
            ncol = 0;
            shifted = '0;
         end
         if (frame_done) begin
            chk("rows_per_frame", rows_in_frame, ROWS);
            if (last_fd >= 0) chk("frame_spacing", cyc - last_fd, FRAME_PERIOD);
            last_fd = cyc;
            rows_in_frame = 0;
            frame_idx++;
            fd_total++;
            exp_scene = live_scene();
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic rand_inputs();
      bx  = CW'($urandom_range(0, COLS - 1));
      by  = RW'($urandom_range(0, ROWS - 1));
      p1y = RW'($urandom_range(0, ROWS - 1));
      p2y = RW'($urandom_range(0, ROWS - 1));
      sc1 = SCORE_W'($urandom_range(0, (1 << SCORE_W) - 1));
      sc2 = SCORE_W'($urandom_range(0, (1 << SCORE_W) - 1));
   endtask

   task automatic wait_fd(input int budget);
      int start;
      int n;
      start = fd_total;
      n = 0;
      while (fd_total == start && n < budget) begin
         step(1);
         n++;
      end
      chk("frame_done_seen", fd_total != start, 1'b1);
   endtask

   task automatic wait_latch_row(input int r, input int budget);
      int n;
      n = 0;
      while (!(latch && last_latched_row == r) && n < budget) begin
         step(1);
         n++;
      end
      chk("latch_row_seen", latch && last_latched_row == r, 1'b1);
   endtask

   initial begin
      int lt;
      rst = 1'b1;
      step(3);
      chk("rst_sdata", sdata, 1'b0);
      chk("rst_sclk", sclk, 1'b0);
      chk("rst_latch", latch, 1'b0);
      chk("rst_oe_n", oe_n, 1'b1);
      chk("rst_row_addr", row_addr, 0);
      chk("rst_frame_done", frame_done, 1'b0);
      rst = 1'b0;
      step(4);
      chk("idle_oe_n", oe_n, 1'b1);
      chk("idle_sclk", sclk, 1'b0);

      bx = 20; by = 20; p1y = 20; p2y = 20; sc1 = 5; sc2 = 3;
      exp_scene = live_scene();
      enable = 1'b1;
      step(5 * ROW_PERIOD);
      bx = 30;
      wait_fd(FRAME_PERIOD + ROW_PERIOD);

      step(3 * ROW_PERIOD);
      p1y = 60;
      bx  = CW'($urandom_range(1, COLS - 2));
      by  = RW'($urandom_range(0, ROWS - 1));
      p2y = RW'($urandom_range(0, ROWS - 1));
      sc1 = SCORE_W'($urandom_range(0, 7));
      sc2 = SCORE_W'($urandom_range(0, 7));
      wait_fd(FRAME_PERIOD + ROW_PERIOD);

      step(7 * ROW_PERIOD);
      rand_inputs();
      wait_fd(FRAME_PERIOD + ROW_PERIOD);

      step(11 * ROW_PERIOD);
      rand_inputs();
      wait_fd(FRAME_PERIOD + ROW_PERIOD);

      wait_latch_row(9, 11 * ROW_PERIOD);
      step(HOLD_CYCLES + 21);
      chk("pre_reset_row_addr", row_addr, 9);
      rst = 1'b1;
      #1;
      chk("mid_rst_oe_n", oe_n, 1'b1);
      chk("mid_rst_row_addr", row_addr, 0);
      chk("mid_rst_sclk", sclk, 1'b0);
      rand_inputs();
      exp_scene = live_scene();
      step(2);
      rst = 1'b0;

      step(20 * ROW_PERIOD);
      enable = 1'b0;
      rand_inputs();
      wait_fd(FRAME_PERIOD);
      lt = latch_total;
      step(3 * ROW_PERIOD);
      chk("idle_no_latch", latch_total - lt, 0);
      chk("idle_after_frame_oe_n", oe_n, 1'b1);
      chk("idle_after_frame_sclk", sclk, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

endmodule
